ssd_scan_driver: RTL and testbench

- Parametrised seven-segment display driver for the board I/O path (successor to the fixed 13-bit ssd output).
- Accepts a binary value on a load strobe and converts it to BCD sequentially with a shift-add-3 (double-dabble) engine.
- Time-multiplexes DIGITS digits with a refresh counter, with optional signed display and overflow indication.
- Sits between the CPU's display-select mux and the board anode/segment pins.

---
 rtl/ssd_pkg.sv | 31 +++
 rtl/bin2bcd_seq.sv | 54 +++++
 rtl/ssd_scan_driver.sv | 152 +++++++++++++++
 tb/tb_ssd_scan_driver.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/ssd_pkg.sv
// ssd_pkg: digit codes, FSM states, glyph table and BCD sizing for ssd_scan_driver
//   digit_t    4-bit digit code: 0-9 numerals, DIG_MINUS, DIG_DASH, DIG_BLANK
//   glyph()    code -> active-high segments {g,f,e,d,c,b,a}
//   bcd_digits ceil(w*log10(2)) decimal digits for a w-bit binary value
package ssd_pkg;
  typedef logic [3:0] digit_t;
  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;
  localparam digit_t DIG_MINUS = 4'hA;
  localparam digit_t DIG_DASH = 4'hB;
  localparam digit_t DIG_BLANK = 4'hF;
  localparam logic [6:0] GLYPH_0 = 7'h3F;
  function automatic int bcd_digits(input int w);
    return (w * 30103 + 99999) / 100000;
  endfunction
  function automatic logic [6:0] glyph(input digit_t d);
    case (d)
      4'd0: return GLYPH_0;
      4'd1: return 7'h06;
      4'd2: return 7'h5B;
      4'd3: return 7'h4F;
      4'd4: return 7'h66;
      4'd5: return 7'h6D;
      4'd6: return 7'h7D;
      4'd7: return 7'h07;
      4'd8: return 7'h7F;
      4'd9: return 7'h6F;
      DIG_MINUS, DIG_DASH: return 7'h40;
      default: return 7'h00;
    endcase
  endfunction
endpackage

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential shift-add-3 binary to BCD converter, one bit per cycle
//   clk, reset   clock, async active-low reset
//   start_i      load bin_i and begin DATA_W shift steps
//   bin_i        magnitude, DATA_W+1 bits; the top bit is always zero
//   busy_o       shift steps remaining
//   done_o       high during the final shift step (bcd_o valid next cycle)
//   bcd_o        NBCD packed BCD digits, digit 0 in bits [3:0]
module bin2bcd_seq #(
  parameter int DATA_W = 13,
  parameter int NBCD = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic start_i,
  input  logic [DATA_W:0] bin_i,
  output logic busy_o,
  output logic done_o,
  output logic [4*NBCD-1:0] bcd_o
);
  localparam int CW = $clog2(DATA_W + 1);
  logic [DATA_W:0] bin_q, bin_d;
  logic [4*NBCD-1:0] bcd_q, bcd_d, adj;
  logic [CW-1:0] cnt_q, cnt_d;
  assign busy_o = cnt_q != '0;
  assign done_o = cnt_q == CW'(1);
  assign bcd_o = bcd_q;
  always_comb begin
    adj = bcd_q;
    for (int i = 0; i < NBCD; i++)
      adj[4*i +: 4] = bcd_q[4*i +: 4] > 4'd4 ? bcd_q[4*i +: 4] + 4'd3 : bcd_q[4*i +: 4];
    bin_d = bin_q;
    bcd_d = bcd_q;
    cnt_d = cnt_q;
    if (start_i) begin
      bin_d = bin_i;
      bcd_d = '0;
      cnt_d = CW'(DATA_W);
    end else if (busy_o) begin
      bcd_d = {adj[4*NBCD-2:0], bin_q[DATA_W-1]};
      bin_d = bin_q << 1;
      cnt_d = cnt_q - 1'b1;
    end
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      bin_q <= '0;
      bcd_q <= '0;
      cnt_q <= '0;
    end else begin
      bin_q <= bin_d;
      bcd_q <= bcd_d;
      cnt_q <= cnt_d;
    end
endmodule

// File: rtl/ssd_scan_driver.sv
// ssd_scan_driver: load/convert/commit control plus scanned seven-segment output
//   clk, reset   clock, async active-low reset
//   value        binary value, captured with load (signed_en selects two's complement)
//   load         one-cycle strobe; while busy it overwrites a single pending slot
//   anode        one-hot active-low digit enable, bit 0 = least significant digit
//   seg          {g,f,e,d,c,b,a}, inverted when SEG_ACTIVE_LOW
//   busy, done, overflow  conversion status, commit pulse, committed value too wide
// Optional: define SSD_LEAD_ZERO_BLANK_EN to blank leading zeros and float the minus sign.
module ssd_scan_driver import ssd_pkg::*; #(
  parameter int DATA_W = 13,
  parameter int DIGITS = 4,
  parameter int REFRESH_DIV = 100000,
  parameter int SEG_ACTIVE_LOW = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic [DATA_W-1:0] value,
  input  logic signed_en,
  input  logic load,
  output logic [DIGITS-1:0] anode,
  output logic [6:0] seg,
  output logic busy,
  output logic done,
  output logic overflow
);
  localparam int NBCD = bcd_digits(DATA_W);
  localparam int NX = NBCD > DIGITS ? NBCD : DIGITS;
  localparam int CW = REFRESH_DIV > 1 ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;
  localparam logic [6:0] SEG_RST = SEG_ACTIVE_LOW != 0 ? ~GLYPH_0 : GLYPH_0;
  state_t state_q, state_d;
  logic pend_q, pend_d, psgn_q, psgn_d, neg_q, neg_d, ovf_q, ovf_d, ovf;
  logic [DATA_W-1:0] pval_q, pval_d, src_val;
  logic src_sgn, neg_s, start, eng_busy, eng_last, wrap;
  logic [DATA_W:0] mag;
  logic [4*NBCD-1:0] bcd;
  logic [4*NX-1:0] bcdx;
  digit_t [DIGITS-1:0] code, disp_q, disp_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [DIGITS-1:0] anode_q, anode_d;
  logic [6:0] seg_q, seg_d, seg_raw;
  assign busy = state_q != IDLE || pend_q || eng_busy;
  assign done = state_q == COMMIT;
  assign overflow = ovf_q;
  assign anode = anode_q;
  assign seg = seg_q;
  // one extra bit so that -2^(DATA_W-1) negates to its true magnitude
  assign neg_s = src_sgn && src_val[DATA_W-1];
  assign mag = neg_s ? -{src_val[DATA_W-1], src_val} : {1'b0, src_val};
  assign bcdx = (4*NX)'(bcd);
  bin2bcd_seq #(.DATA_W(DATA_W), .NBCD(NBCD)) u_bcd (
    .clk(clk),
    .reset(reset),
    .start_i(start),
    .bin_i(mag),
    .busy_o(eng_busy),
    .done_o(eng_last),
    .bcd_o(bcd)
  );
  always_comb begin
    state_d = state_q;
    pend_d = pend_q;
    pval_d = pval_q;
    psgn_d = psgn_q;
    neg_d = neg_q;
    start = 1'b0;
    src_val = value;
    src_sgn = signed_en;
    case (state_q)
      IDLE: begin
        start = load;
        state_d = load ? SHIFT : IDLE;
      end
      SHIFT: state_d = eng_last ? COMMIT : SHIFT;
      COMMIT: begin
        // a load arriving in this cycle supersedes the pending slot and restarts at once
        start = load || pend_q;
        src_val = load ? value : pval_q;
        src_sgn = load ? signed_en : psgn_q;
        state_d = start ? SHIFT : IDLE;
        pend_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase
    if (load && state_q == SHIFT) begin
      pend_d = 1'b1;
      pval_d = value;
      psgn_d = signed_en;
    end
    if (start) neg_d = neg_s;
  end
  always_comb begin
    ovf = 1'b0;
    for (int i = 0; i < NX; i++)
      if (bcdx[4*i +: 4] != 4'd0 && i >= DIGITS - int'(neg_q)) ovf = 1'b1;
`ifdef SSD_LEAD_ZERO_BLANK_EN
    begin
      int msd;
      msd = 0;
      for (int i = 0; i < DIGITS; i++)
        if (bcdx[4*i +: 4] != 4'd0) msd = i;
      for (int i = 0; i < DIGITS; i++) begin
        code[i] = i <= msd ? digit_t'(bcdx[4*i +: 4]) : (neg_q && i == msd + 1) ? DIG_MINUS : DIG_BLANK;
        if (ovf) code[i] = DIG_DASH;
      end
    end
`else
    for (int i = 0; i < DIGITS; i++) begin
      code[i] = (neg_q && i == DIGITS - 1) ? DIG_MINUS : digit_t'(bcdx[4*i +: 4]);
      if (ovf) code[i] = DIG_DASH;
    end
`endif
  end
  // anode/seg are built from next-cycle state so a commit shows on the very next clock
  always_comb begin
    disp_d = state_q == COMMIT ? code : disp_q;
    ovf_d = state_q == COMMIT ? ovf : ovf_q;
    wrap = cnt_q == CW'(REFRESH_DIV - 1);
    cnt_d = wrap ? '0 : cnt_q + 1'b1;
    idx_d = wrap ? (idx_q == IW'(DIGITS - 1) ? '0 : idx_q + 1'b1) : idx_q;
    anode_d = ~(DIGITS'(1) << idx_d);
    seg_raw = glyph(disp_d[idx_d]);
    seg_d = SEG_ACTIVE_LOW != 0 ? ~seg_raw : seg_raw;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state_q <= IDLE;
      pend_q <= 1'b0;
      pval_q <= '0;
      psgn_q <= 1'b0;
      neg_q <= 1'b0;
      ovf_q <= 1'b0;
      disp_q <= '0;
      cnt_q <= '0;
      idx_q <= '0;
      anode_q <= ~DIGITS'(1);
      seg_q <= SEG_RST;
    end else begin
      state_q <= state_d;
      pend_q <= pend_d;
      pval_q <= pval_d;
      psgn_q <= psgn_d;
      neg_q <= neg_d;
      ovf_q <= ovf_d;
      disp_q <= disp_d;
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      anode_q <= anode_d;
      seg_q <= seg_d;
    end
endmodule

// File: tb/tb_ssd_scan_driver.sv
// tb_ssd_scan_driver: randomized scoreboard bench for ssd_scan_driver (13-bit, 4 digits, refresh 4)
module tb_ssd_scan_driver;
  logic clk = 1'b0, reset = 1'b0, signed_en = 1'b0, load = 1'b0;
  logic [12:0] value = '0;
  logic [3:0] anode;
  logic [6:0] seg;
  logic busy, done, overflow;
  typedef struct {string s; bit ovf; int cyc;} exp_t;
  exp_t q[$];
  int cyc = 0, cur_done = -100, rls = 0, rd = 0, nchk = 0, nerr = 0;
  bit pend = 1'b0, ps = 1'b0, fin = 1'b0;
  logic [12:0] pv = '0;

  always #5 clk = ~clk;

  ssd_scan_driver #(.DATA_W(13), .DIGITS(4), .REFRESH_DIV(4), .SEG_ACTIVE_LOW(1)) dut (
    .clk(clk), .reset(reset), .value(value), .signed_en(signed_en), .load(load),
    .anode(anode), .seg(seg), .busy(busy), .done(done), .overflow(overflow)
  );

  function automatic logic [6:0] gl(input byte c);
    case (c)
      "0": return 7'h3F;
      "1": return 7'h06;
      "2": return 7'h5B;
      "3": return 7'h4F;
      "4": return 7'h66;
      "5": return 7'h6D;
      "6": return 7'h7D;
      "7": return 7'h07;
      "8": return 7'h7F;
      "9": return 7'h6F;
      "-": return 7'h40;
      default: return 7'h00;
    endcase
  endfunction

  // expected display text, most significant digit first
  function automatic exp_t expect_of(input logic [12:0] v, input bit s, input int at);
    exp_t x;
    int n;
    bit neg;
    string t;
    neg = s && v[12];
    n = neg ? 8192 - int'(v) : int'(v);
    x.ovf = n > 9999 || (neg && n > 999);
`ifdef SSD_LEAD_ZERO_BLANK_EN
    t = neg ? $sformatf("-%0d", n) : $sformatf("%0d", n);
    while (t.len() < 4) t = {" ", t};
`else
    t = neg ? $sformatf("-%03d", n) : $sformatf("%04d", n);
`endif
    x.s = x.ovf ? "----" : t;
    x.cyc = at;
    return x;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // protocol model: a conversion accepted at edge e commits 13 edges later; loads while busy
  // overwrite one pending slot, which starts on the edge after the commit
  initial forever begin
    @(posedge clk);
    cyc++;
    if (!reset) begin
      cur_done = -100;
      pend = 1'b0;
    end else if (cyc == cur_done + 1 && pend && !load) begin
      q.push_back(expect_of(pv, ps, cyc + 13));
      cur_done = cyc + 13;
      pend = 1'b0;
    end else if (load) begin
      if (cyc <= cur_done) begin
        pend = 1'b1;
        pv = value;
        ps = signed_en;
      end else begin
        q.push_back(expect_of(value, signed_en, cyc + 13));
        cur_done = cyc + 13;
        pend = 1'b0;
      end
    end
  end

  initial begin
    string ds;
    bit ovf_e, upd, due;
    exp_t nx;
    int idx;
    logic [3:0] ea;
    logic [6:0] es;
    ds = "0000";
    ovf_e = 1'b0;
    upd = 1'b0;
    forever begin
      @(negedge clk);
      if (fin) begin
        chk("queue_drained", rd, q.size());
        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
      end
      if (upd) begin
        ds = nx.s;
        ovf_e = nx.ovf;
        upd = 1'b0;
      end
      if (!reset) begin
        ds = "0000";
        ovf_e = 1'b0;
        rd = q.size();
        es = ~gl("0");
        chk("rst_anode", int'(anode), 4'b1110);
        chk("rst_seg", int'(seg), int'(es));
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_overflow", int'(overflow), 0);
      end else begin
        due = rd < q.size() && q[rd].cyc == cyc;
        if (done || due) begin
          if (rd >= q.size()) chk("spurious_done", int'(done), 0);
          else begin
            chk("done_pulse", int'(done), 1);
            chk("done_cycle", cyc, q[rd].cyc);
            nx = q[rd];
            rd++;
            upd = 1'b1;
          end
        end
        idx = ((cyc - rls) / 4) % 4;
        ea = ~(4'b0001 << idx);
        es = ~gl(ds[3 - idx]);
        chk("anode", int'(anode), int'(ea));
        chk("seg", int'(seg), int'(es));
        chk("overflow", int'(overflow), int'(ovf_e));
        chk("busy", int'(busy), int'(cyc <= cur_done || pend));
      end
    end
  end

  task automatic ld(input logic [12:0] v, input bit s);
    @(negedge clk);
    #1 value = v;
    signed_en = s;
    load = 1'b1;
    @(negedge clk);
    #1 load = 1'b0;
  endtask

  task automatic settle();
    for (int i = 0; i < 400 && (cur_done >= cyc || pend); i++) @(negedge clk);
    repeat (20) @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;
    rls = cyc;
    repeat (40) @(negedge clk);
    ld(13'd1234, 1'b0); settle();
    ld(13'(-42), 1'b1); settle();
    ld(13'd4095, 1'b0); settle();
    ld(13'h1000, 1'b1); settle();
    ld(13'd7, 1'b0); settle();
    ld(13'd100, 1'b0);
    repeat (2) @(negedge clk);
    ld(13'd200, 1'b0);
    repeat (2) @(negedge clk);
    ld(13'd300, 1'b0);
    settle();
    ld(13'd555, 1'b0);
    repeat (4) @(negedge clk);
    #2 reset = 1'b0;
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;
    rls = cyc;
    repeat (40) @(negedge clk);
    for (int n = 0; n < 40; n++) begin
      ld(13'($urandom_range(0, 8191)), 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 20)) @(negedge clk);
    end
    settle();
    #1 fin = 1'b1;
    repeat (5) @(negedge clk);
    $display("FAIL monitor: summary not reached");
    $fatal(1);
  end
endmodule
